// File: rtl/velocimetro_pkg.sv
// -----------------------------------------------------------------------------
// velocimetro_pkg
// Shared definitions for the speedometer measurement-window logic:
//   - gate_state_e : window controller states (IDLE, GATE, LATCH)
//   - DEFAULT_*    : default timebase / window / counter sizing
//   - cntWidth()   : width of a counter that runs 0..maxCount-1
// -----------------------------------------------------------------------------
package velocimetro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } gate_state_e;

  localparam int unsigned DEFAULT_TICK_DIV   = 10000000;
  localparam int unsigned DEFAULT_GATE_TICKS = 2;
  localparam int unsigned DEFAULT_CNT_W      = 16;

  // A counter with a single state still needs one bit to exist.
  function automatic int unsigned cntWidth(input int unsigned maxCount);
    return (maxCount <= 2) ? 1 : $clog2(maxCount);
  endfunction

endpackage

// File: rtl/velocimetro_gate_ctrl_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Timebase divider: counts 0..TICK_DIV-1 while 'run' is high and emits a
// one-cycle 'tick' on the last count before wrapping. Held at 0 while 'run'
// is low and cleared whenever 'clear' is high.
// Ports:
//   clock  in  system clock, rising edge
//   resetn in  asynchronous active-low reset
//   clear  in  synchronous clear of the count
//   run    in  count enable; low holds the count at 0
//   tick   out one-cycle pulse at count TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_prescaler
  import velocimetro_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned W = cntWidth(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !run) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/velocimetro_gate_ctrl.sv
// -----------------------------------------------------------------------------
// velocimetro_gate_ctrl
// Measurement-window controller for the speedometer. Opens gate windows of
// GATE_TICKS timebase ticks, counts synchronized rising edges of the wheel
// sensor inside each window, and latches the count with a one-cycle strobe.
// Windows run back-to-back (one LATCH cycle between them) while enabled.
// Ports:
//   clock       in  system clock, rising edge
//   resetn      in  asynchronous active-low reset
//   enable      in  high = run windows continuously, low = abort / idle
//   sensor_in   in  raw wheel sensor, asynchronous to clock
//   gate        out high while a window is open
//   busy        out high whenever the controller is not idle
//   count_out   out edge count of the last completed window
//   count_valid out one-cycle strobe, count_out updated this cycle
//   overflow    out last completed window saturated the counter
// -----------------------------------------------------------------------------
module velocimetro_gate_ctrl
  import velocimetro_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEFAULT_TICK_DIV,
  parameter int unsigned GATE_TICKS = DEFAULT_GATE_TICKS,
  parameter int unsigned CNT_W      = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             sensor_in,
  output logic             gate,
  output logic             busy,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow
);

  localparam int unsigned TW = cntWidth(GATE_TICKS);
  localparam logic [TW-1:0] LAST_TICK = TW'(GATE_TICKS - 1);

  gate_state_e state_q, state_d;

  logic sync1_q, sync2_q, prev_q;
  logic edgeEvt;

  logic [TW-1:0]    tickCnt_q, tickCnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic tick;
  logic inGate;
  logic windowDone;
  logic gateEntry;
  logic latchEntry;

  // Two flops resolve metastability, the third remembers the previous level.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sensor_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edgeEvt = sync2_q & ~prev_q;

  assign inGate = (state_q == GATE);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .resetn(resetn),
    .clear (gateEntry),
    .run   (inGate),
    .tick  (tick)
  );

  assign windowDone = inGate && tick && (tickCnt_q == LAST_TICK);

  // Abort is checked before completion so a drop of enable on the final
  // GATE cycle discards the window instead of latching it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = GATE;
      GATE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (windowDone) begin
          state_d = LATCH;
        end
      end
      LATCH:   state_d = enable ? GATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gateEntry  = (state_d == GATE) && (state_q != GATE);
  assign latchEntry = (state_d == LATCH);

  always_comb begin
    tickCnt_d = tickCnt_q;
    if (gateEntry) begin
      tickCnt_d = '0;
    end else if (inGate && tick) begin
      tickCnt_d = (tickCnt_q == LAST_TICK) ? '0 : tickCnt_q + 1'b1;
    end
  end

  // Saturating edge accumulator; sat records any increment attempted at
  // all-ones so the window is flagged even if more edges follow.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (gateEntry) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (inGate && edgeEvt) begin
      if (&acc_q) begin
        sat_d = 1'b1;
      end else begin
        acc_d = acc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      tickCnt_q <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tickCnt_q <= tickCnt_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
    end
  end

  // Latch from acc_d so an edge in the final GATE cycle is included.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (latchEntry) begin
      count_q    <= acc_d;
      overflow_q <= sat_d;
    end
  end

  assign gate        = inGate;
  assign busy        = (state_q != IDLE);
  assign count_valid = (state_q == LATCH);
  assign count_out   = count_q;
  assign overflow    = overflow_q;

endmodule
